// File: rtl/sal_bank_ctrl.sv
// Per-bank DDR2 command sequencer: single-entry request buffer, open-page
// policy, and bank-local ACT/RD/WR/PRE timing enforcement.
module sal_bank_ctrl #(
    parameter int unsigned ID_WIDTH  = 4,
    parameter int unsigned RA_WIDTH  = 14,
    parameter int unsigned CA_WIDTH  = 10,
    parameter int unsigned LEN_WIDTH = 4,
    parameter int unsigned T_RCD     = 4,
    parameter int unsigned T_RP      = 4,
    parameter int unsigned T_RAS     = 12,
    parameter int unsigned T_RTP     = 2,
    parameter int unsigned T_WTP     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ID_WIDTH-1:0]  req_id,
    input  logic [RA_WIDTH-1:0]  req_ra,
    input  logic [CA_WIDTH-1:0]  req_ca,
    input  logic [LEN_WIDTH-1:0] req_len,
    input  logic                 req_wr,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [1:0]           cmd_type,
    output logic [RA_WIDTH-1:0]  cmd_ra,
    output logic [CA_WIDTH-1:0]  cmd_ca,
    output logic [ID_WIDTH-1:0]  cmd_id,
    output logic [LEN_WIDTH-1:0] cmd_len,
    output logic                 bank_open,
    output logic [RA_WIDTH-1:0]  open_row
);

    localparam int unsigned T_M1  = (T_RCD > T_RP)  ? T_RCD : T_RP;
    localparam int unsigned T_M2  = (T_RAS > T_RTP) ? T_RAS : T_RTP;
    localparam int unsigned T_M3  = (T_M1 > T_M2)   ? T_M1  : T_M2;
    localparam int unsigned T_MAX = (T_M3 > T_WTP)  ? T_M3  : T_WTP;
    localparam int unsigned CNT_W = $clog2(T_MAX + 1);

    typedef enum logic {
        ST_CLOSED = 1'b0,
        ST_OPEN   = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        CMD_ACT = 2'd0,
        CMD_RD  = 2'd1,
        CMD_WR  = 2'd2,
        CMD_PRE = 2'd3
    } cmd_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]  id;
        logic [RA_WIDTH-1:0]  ra;
        logic [CA_WIDTH-1:0]  ca;
        logic [LEN_WIDTH-1:0] len;
        logic                 wr;
    } req_t;

    state_t               state_q,     state_d;
    logic                 buf_valid_q, buf_valid_d;
    req_t                 buf_q,       buf_d;
    logic [CNT_W-1:0]     rcd_q,       rcd_d;
    logic [CNT_W-1:0]     ras_q,       ras_d;
    logic [CNT_W-1:0]     rp_q,        rp_d;
    logic [CNT_W-1:0]     pblk_q,      pblk_d;
    logic                 bank_open_q, bank_open_d;
    logic [RA_WIDTH-1:0]  open_row_q,  open_row_d;
    logic                 cmd_valid_q, cmd_valid_d;
    cmd_t                 cmd_type_q,  cmd_type_d;
    logic [RA_WIDTH-1:0]  cmd_ra_q,    cmd_ra_d;
    logic [CA_WIDTH-1:0]  cmd_ca_q,    cmd_ca_d;
    logic [ID_WIDTH-1:0]  cmd_id_q,    cmd_id_d;
    logic [LEN_WIDTH-1:0] cmd_len_q,   cmd_len_d;
    logic                 req_ready_q, req_ready_d;

    logic grant;
    logic accept;

    function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
        return (v == '0) ? v : v - CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_max(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign grant  = cmd_valid_q & cmd_ready;
    assign accept = req_valid & req_ready_q;

    // Next-state: apply grant/accept effects, then pick the command to present
    // from the resulting state so cmd_valid is registered yet never late.
    always_comb begin
        state_d     = state_q;
        buf_valid_d = buf_valid_q;
        buf_d       = buf_q;
        rcd_d       = dec_sat(rcd_q);
        ras_d       = dec_sat(ras_q);
        rp_d        = dec_sat(rp_q);
        pblk_d      = dec_sat(pblk_q);
        bank_open_d = bank_open_q;
        open_row_d  = open_row_q;
        cmd_valid_d = cmd_valid_q;
        cmd_type_d  = cmd_type_q;
        cmd_ra_d    = cmd_ra_q;
        cmd_ca_d    = cmd_ca_q;
        cmd_id_d    = cmd_id_q;
        cmd_len_d   = cmd_len_q;

        if (grant) begin
            case (cmd_type_q)
                CMD_ACT: begin
                    state_d     = ST_OPEN;
                    bank_open_d = 1'b1;
                    open_row_d  = cmd_ra_q;
                    rcd_d       = CNT_W'(T_RCD - 1);
                    ras_d       = CNT_W'(T_RAS - 1);
                end
                CMD_RD: begin
                    buf_valid_d = 1'b0;
                    pblk_d      = cnt_max(pblk_q, CNT_W'(T_RTP - 1));
                end
                CMD_WR: begin
                    buf_valid_d = 1'b0;
                    pblk_d      = cnt_max(pblk_q, CNT_W'(T_WTP - 1));
                end
                default: begin
                    state_d     = ST_CLOSED;
                    bank_open_d = 1'b0;
                    rp_d        = CNT_W'(T_RP - 1);
                end
            endcase
        end

        if (accept) begin
            buf_valid_d = 1'b1;
            buf_d       = '{id: req_id, ra: req_ra, ca: req_ca, len: req_len, wr: req_wr};
        end

        if (!(cmd_valid_q && !cmd_ready)) begin
            cmd_valid_d = 1'b0;
            if (buf_valid_d) begin
                if (state_d == ST_CLOSED) begin
                    if (rp_d == '0) begin
                        cmd_valid_d = 1'b1;
                        cmd_type_d  = CMD_ACT;
                    end
                end else if (buf_d.ra == open_row_d) begin
                    if (rcd_d == '0) begin
                        cmd_valid_d = 1'b1;
                        cmd_type_d  = buf_d.wr ? CMD_WR : CMD_RD;
                    end
                end else if (ras_d == '0 && pblk_d == '0) begin
                    cmd_valid_d = 1'b1;
                    cmd_type_d  = CMD_PRE;
                end
                if (cmd_valid_d) begin
                    cmd_ra_d  = buf_d.ra;
                    cmd_ca_d  = buf_d.ca;
                    cmd_id_d  = buf_d.id;
                    cmd_len_d = buf_d.len;
                end
            end
        end

        req_ready_d = !buf_valid_d;
    end

    // State register for buffer, FSM, timers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLOSED;
            buf_valid_q <= 1'b0;
            buf_q       <= '0;
            rcd_q       <= '0;
            ras_q       <= '0;
            rp_q        <= '0;
            pblk_q      <= '0;
            bank_open_q <= 1'b0;
            open_row_q  <= '0;
            cmd_valid_q <= 1'b0;
            cmd_type_q  <= CMD_ACT;
            cmd_ra_q    <= '0;
            cmd_ca_q    <= '0;
            cmd_id_q    <= '0;
            cmd_len_q   <= '0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_q       <= buf_d;
            rcd_q       <= rcd_d;
            ras_q       <= ras_d;
            rp_q        <= rp_d;
            pblk_q      <= pblk_d;
            bank_open_q <= bank_open_d;
            open_row_q  <= open_row_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_type_q  <= cmd_type_d;
            cmd_ra_q    <= cmd_ra_d;
            cmd_ca_q    <= cmd_ca_d;
            cmd_id_q    <= cmd_id_d;
            cmd_len_q   <= cmd_len_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign req_ready = req_ready_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_type  = cmd_type_q;
    assign cmd_ra    = cmd_ra_q;
    assign cmd_ca    = cmd_ca_q;
    assign cmd_id    = cmd_id_q;
    assign cmd_len   = cmd_len_q;
    assign bank_open = bank_open_q;
    assign open_row  = open_row_q;

endmodule

// File: tb/tb_sal_bank_ctrl.sv
// Directed bench for sal_bank_ctrl: closed-bank read, row hit, row miss,
// write-to-precharge, scheduler backpressure and mid-operation reset.
module tb_sal_bank_ctrl;

    localparam int unsigned T_RCD = 4;
    localparam int unsigned T_RP  = 4;
    localparam int unsigned T_RAS = 12;
    localparam int unsigned T_RTP = 2;
    localparam int unsigned T_WTP = 8;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_id;
    logic [13:0] req_ra;
    logic [9:0]  req_ca;
    logic [3:0]  req_len;
    logic        req_wr;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [13:0] cmd_ra;
    logic [9:0]  cmd_ca;
    logic [3:0]  cmd_id;
    logic [3:0]  cmd_len;
    logic        bank_open;
    logic [13:0] open_row;

    int n_cmp;
    int n_err;
    int cyc;

    sal_bank_ctrl #(
        .ID_WIDTH(4), .RA_WIDTH(14), .CA_WIDTH(10), .LEN_WIDTH(4),
        .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS), .T_RTP(T_RTP), .T_WTP(T_WTP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_id(req_id), .req_ra(req_ra), .req_ca(req_ca),
        .req_len(req_len), .req_wr(req_wr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_ra(cmd_ra), .cmd_ca(cmd_ca), .cmd_id(cmd_id), .cmd_len(cmd_len),
        .bank_open(bank_open), .open_row(open_row)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle index; never reset so latencies survive rst_n pulses.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int c);
        int n;
        n = 0;
        while (!cmd_valid && n < 100) begin
            tick();
            n++;
        end
        if (!cmd_valid) check("cmd_timeout", 32'd0, 32'd1);
        c = cyc;
    endtask

    task automatic send_req(input logic [13:0] ra, input logic [9:0] ca,
                            input logic [3:0] id, input logic [3:0] len,
                            input logic wr, output int acc);
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        if (!req_ready) check("req_timeout", 32'd0, 32'd1);
        req_valid = 1'b1;
        req_ra    = ra;
        req_ca    = ca;
        req_id    = id;
        req_len   = len;
        req_wr    = wr;
        acc       = cyc;
        tick();
        req_valid = 1'b0;
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    int acc, c, c_act, c_rd, c_rd2, c_pre, c_act2, c_wr, exp_pre;

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0;
        rst_n = 1'b0; req_valid = 1'b0; cmd_ready = 1'b1;
        req_id = '0; req_ra = '0; req_ca = '0; req_len = '0; req_wr = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_bank_open", 32'(bank_open), 32'd0);
        check("rst_open_row",  32'(open_row),  32'd0);
        check("rst_cmd_ra",    32'(cmd_ra),    32'd0);

        // Closed bank read: ACT the cycle after accept, RD T_RCD after ACT grant
        send_req(14'h12, 10'h40, 4'd3, 4'd3, 1'b0, acc);
        check("act_valid", 32'(cmd_valid), 32'd1);
        check("act_lat",   32'(cyc - acc), 32'd1);
        check("act_type",  32'(cmd_type),  32'd0);
        check("act_ra",    32'(cmd_ra),    32'h12);
        check("busy_after_accept", 32'(req_ready), 32'd0);
        c_act = cyc;
        tick();
        wait_valid(c);
        check("rd_lat",  32'(c - c_act), 32'(T_RCD));
        check("rd_type", 32'(cmd_type),  32'd1);
        check("rd_ca",   32'(cmd_ca),    32'h40);
        check("rd_id",   32'(cmd_id),    32'd3);
        check("rd_len",  32'(cmd_len),   32'd3);
        c_rd = c;
        tick();
        check("open_after_act", 32'(bank_open), 32'd1);
        check("open_row_12",    32'(open_row),  32'h12);
        check("ready_after_rd", 32'(req_ready), 32'd1);

        // Row hit: back-to-back RD two cycles after previous grant, no ACT
        send_req(14'h12, 10'h80, 4'd5, 4'd1, 1'b0, acc);
        check("hit_busy",  32'(req_ready), 32'd0);
        check("hit_valid", 32'(cmd_valid), 32'd1);
        check("hit_type",  32'(cmd_type),  32'd1);
        check("hit_ca",    32'(cmd_ca),    32'h80);
        check("hit_id",    32'(cmd_id),    32'd5);
        c_rd2 = cyc;
        check("hit_b2b", 32'(c_rd2 - c_rd), 32'd2);
        tick();
        check("hit_rearm", 32'(req_ready), 32'd1);

        // Row miss: PRE gated by tRAS, then ACT after tRP, then RD after tRCD
        send_req(14'h20, 10'h08, 4'd9, 4'd2, 1'b0, acc);
        wait_valid(c);
        exp_pre = imax(imax(acc + 1, c_act + int'(T_RAS)), c_rd2 + int'(T_RTP));
        check("miss_pre_at",   32'(c),        32'(exp_pre));
        check("miss_pre_type", 32'(cmd_type), 32'd3);
        c_pre = c;
        tick();
        check("closed_after_pre", 32'(bank_open), 32'd0);
        check("row_held",         32'(open_row),  32'h12);
        wait_valid(c);
        check("miss_act_lat", 32'(c - c_pre), 32'(T_RP));
        check("miss_act_type", 32'(cmd_type), 32'd0);
        check("miss_act_ra",  32'(cmd_ra),    32'h20);
        c_act2 = c;
        tick();
        wait_valid(c);
        check("miss_rd_lat",  32'(c - c_act2), 32'(T_RCD));
        check("miss_rd_type", 32'(cmd_type),   32'd1);
        check("miss_rd_ca",   32'(cmd_ca),     32'h08);
        check("miss_rd_id",   32'(cmd_id),     32'd9);
        tick();

        // Write with tRAS long expired, then miss: PRE exactly T_WTP after WR
        repeat (T_RAS) tick();
        send_req(14'h20, 10'h10, 4'd7, 4'd2, 1'b1, acc);
        check("wr_valid", 32'(cmd_valid), 32'd1);
        check("wr_type",  32'(cmd_type),  32'd2);
        check("wr_ca",    32'(cmd_ca),    32'h10);
        check("wr_id",    32'(cmd_id),    32'd7);
        c_wr = cyc;
        tick();
        send_req(14'h30, 10'h11, 4'd1, 4'd0, 1'b0, acc);
        wait_valid(c);
        check("wtp_pre_lat",  32'(c - c_wr), 32'(T_WTP));
        check("wtp_pre_type", 32'(cmd_type), 32'd3);
        tick();
        wait_valid(c);
        check("wtp_act_ra", 32'(cmd_ra), 32'h30);
        tick();
        wait_valid(c);
        check("wtp_rd_type", 32'(cmd_type), 32'd1);
        tick();

        // Backpressure: ACT held stable while scheduler withholds grant
        cmd_ready = 1'b0;
        send_req(14'h40, 10'h20, 4'd2, 4'd0, 1'b0, acc);
        wait_valid(c);
        check("bp_pre_type", 32'(cmd_type), 32'd3);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("bp_pre_taken", 32'(cmd_valid), 32'd0);
        wait_valid(c);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", 32'(cmd_valid), 32'd1);
            check("bp_hold_type",  32'(cmd_type),  32'd0);
            check("bp_hold_ra",    32'(cmd_ra),    32'h40);
            tick();
        end
        check("bp_still_closed", 32'(bank_open), 32'd0);
        cmd_ready = 1'b1;
        tick();
        check("bp_act_taken", 32'(cmd_valid), 32'd0);
        check("bp_open",      32'(bank_open), 32'd1);
        check("bp_open_row",  32'(open_row),  32'h40);
        wait_valid(c);
        check("bp_rd_type", 32'(cmd_type), 32'd1);
        check("bp_rd_ca",   32'(cmd_ca),   32'h20);
        tick();

        // Reset during the tRCD wait drops the pending request entirely
        send_req(14'h50, 10'h30, 4'd4, 4'd1, 1'b0, acc);
        wait_valid(c);
        tick();
        wait_valid(c);
        check("rr_act_ra", 32'(cmd_ra), 32'h50);
        tick();
        check("rr_in_rcd",   32'(cmd_valid), 32'd0);
        check("rr_pre_busy", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rr_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rr_bank_open", 32'(bank_open), 32'd0);
        check("rr_req_ready", 32'(req_ready), 32'd1);
        check("rr_open_row",  32'(open_row),  32'd0);
        #1;
        rst_n = 1'b1;
        repeat (6) tick();
        check("rr_no_stale_cmd", 32'(cmd_valid), 32'd0);
        send_req(14'h50, 10'h30, 4'd4, 4'd1, 1'b0, acc);
        check("rr_act_type", 32'(cmd_type),  32'd0);
        check("rr_act_valid", 32'(cmd_valid), 32'd1);
        check("rr_act_ra2",  32'(cmd_ra),    32'h50);
        c_act = cyc;
        tick();
        wait_valid(c);
        check("rr_rd_lat",  32'(c - c_act), 32'(T_RCD));
        check("rr_rd_type", 32'(cmd_type),  32'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
